// File: rtl/fpa_reduce_seq_if.sv
// Handshake and data bundle for the sequential FP array reducer.
// The master side starts jobs and supplies operands. The slave side (the reducer)
// reports busy/valid, the folded result and the sticky exception flags.
interface fpa_reduce_seq_if #(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 16
);
  logic                             iEN;
  logic                             iSTART;
  logic [1:0]                       iFPA_MODE;
  logic [N-1:0][DATA_WIDTH-1:0]     iFPA_NUMBERS;
  logic                             oBUSY;
  logic [DATA_WIDTH-1:0]            oFPA_RESULT;
  logic                             oFPA_DATA_VALID;
  logic                             oFPA_OVERFLOW;
  logic                             oFPA_UNDERFLOW;
  logic                             oFPA_EXCEPTION;

  modport master (
    output iEN, iSTART, iFPA_MODE, iFPA_NUMBERS,
    input  oBUSY, oFPA_RESULT, oFPA_DATA_VALID, oFPA_OVERFLOW, oFPA_UNDERFLOW, oFPA_EXCEPTION
  );

  modport slave (
    input  iEN, iSTART, iFPA_MODE, iFPA_NUMBERS,
    output oBUSY, oFPA_RESULT, oFPA_DATA_VALID, oFPA_OVERFLOW, oFPA_UNDERFLOW, oFPA_EXCEPTION
  );
endinterface

// File: rtl/fpa_reduce_seq.sv
// Sequential single-precision array reducer.
// A start pulse in IDLE captures N operands and a mode. One element is then folded per
// enabled clock (sum, alternating sum, max or min). The fold ends in a one-cycle valid
// pulse carrying the result and the sticky overflow/underflow/exception flags for the job.
// The add/subtract datapath is a round-to-nearest-even adder. It flushes denormal inputs
// and results to zero and saturates exponent overflow to infinity.
module fpa_reduce_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 16
) (
  input  logic            iCLK,
  input  logic            iRESET,
  fpa_reduce_seq_if.slave bus
);

  if (DATA_WIDTH != 32) begin : gBadWidth
    $error("fpa_reduce_seq supports DATA_WIDTH == 32 only");
  end

  localparam int          IDXW  = $clog2(N) + 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);
  localparam logic [31:0] QNAN  = 32'h7FC00000;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [N-1:0][31:0]  nums_q, nums_d;
  logic [1:0]          mode_q, mode_d;
  logic [31:0]         acc_q, acc_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic [31:0]         result_q, result_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                exc_q, exc_d;

  logic [31:0]         curX;
  logic                isSub;
  logic [34:0]         addOut;
  logic [31:0]         stepRes;
  logic                stepOvf, stepUnf, stepExc;

  function automatic logic isNan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Strict numeric "x > y" on sign-magnitude values; both zeros compare equal.
  function automatic logic greaterThan(input logic [31:0] x, input logic [31:0] y);
    logic gt;
    if ((x[30:0] == 31'd0) && (y[30:0] == 31'd0)) gt = 1'b0;
    else if (x[31] != y[31])                      gt = y[31];
    else if (!x[31])                              gt = x[30:0] > y[30:0];
    else                                          gt = x[30:0] < y[30:0];
    return gt;
  endfunction

  // Combinational a +/- b. Returns {overflow, underflow, exception, result}.
  function automatic logic [34:0] addSub(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic              sa, sb, aNan, bNan, aInf, bInf, aZero, bZero;
    logic              sBig, sSmall, sticky, found, roundUp, ovf, unf, exc;
    logic [7:0]        eBig, eSmall, shamt;
    logic [26:0]       mBig, mSmall, mAlign, norm;
    logic [27:0]       sum;
    logic [4:0]        lz;
    logic [24:0]       mRound;
    logic [22:0]       frac;
    logic signed [9:0] eRes;
    logic [31:0]       res;
    sa    = a[31];
    sb    = b[31] ^ sub;
    aNan  = isNan(a);
    bNan  = isNan(b);
    aInf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    bInf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    aZero = (a[30:23] == 8'h00);
    bZero = (b[30:23] == 8'h00);
    res = 32'h0;
    ovf = 1'b0;
    unf = 1'b0;
    exc = 1'b0;
    // Order operands by magnitude so the subtraction never goes negative.
    sBig   = sa;
    sSmall = sb;
    eBig   = a[30:23];
    eSmall = b[30:23];
    mBig   = {1'b1, a[22:0], 3'b000};
    mSmall = {1'b1, b[22:0], 3'b000};
    if (b[30:0] > a[30:0]) begin
      sBig   = sb;
      sSmall = sa;
      eBig   = b[30:23];
      eSmall = a[30:23];
      mBig   = {1'b1, b[22:0], 3'b000};
      mSmall = {1'b1, a[22:0], 3'b000};
    end
    // Align with guard, round and sticky bits.
    shamt = eBig - eSmall;
    if (shamt > 8'd26) begin
      mAlign = 27'd0;
      sticky = 1'b1;
    end else begin
      mAlign = mSmall >> shamt;
      sticky = |(mSmall & ~({27{1'b1}} << shamt));
    end
    mAlign[0] = mAlign[0] | sticky;
    if (sBig == sSmall) sum = {1'b0, mBig} + {1'b0, mAlign};
    else                sum = {1'b0, mBig} - {1'b0, mAlign};
    // Normalise: one right shift on carry-out, otherwise remove leading zeros.
    eRes  = $signed({2'b00, eBig});
    lz    = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && sum[i]) begin
        lz    = 5'(26 - i);
        found = 1'b1;
      end
    end
    if (sum[27]) begin
      norm = {sum[27:2], sum[1] | sum[0]};
      eRes = eRes + 10'sd1;
    end else begin
      norm = sum[26:0] << lz;
      eRes = eRes - $signed({5'b00000, lz});
    end
    // Round to nearest, ties to even.
    roundUp = norm[2] & (norm[1] | norm[0] | norm[3]);
    mRound  = {1'b0, norm[26:3]} + {24'd0, roundUp};
    frac    = mRound[22:0];
    if (mRound[24]) begin
      frac = mRound[23:1];
      eRes = eRes + 10'sd1;
    end
    if (aNan || bNan || (aInf && bInf && (sa != sb))) begin
      res = QNAN;
      exc = 1'b1;
    end
    else if (aInf)            res = {sa, 8'hFF, 23'd0};
    else if (bInf)            res = {sb, 8'hFF, 23'd0};
    else if (aZero && bZero)  res = {sa & sb, 31'd0};
    else if (aZero)           res = {sb, b[30:0]};
    else if (bZero)           res = a;
    else if (sum == 28'd0)    res = 32'h0;
    else if (eRes >= 10'sd255) begin
      ovf = 1'b1;
      res = {sBig, 8'hFF, 23'd0};
    end
    else if (eRes <= 10'sd0) begin
      unf = 1'b1;
      res = {sBig, 31'd0};
    end
    else res = {sBig, eRes[7:0], frac};
    return {ovf, unf, exc, res};
  endfunction

  // One fold step: pick x[idx], then either add/subtract it or compare it against acc.
  always_comb begin
    curX = 32'h0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IDXW'(i)) curX = nums_q[i];
    end
    isSub   = (mode_q == 2'b01) && idx_q[0];
    addOut  = addSub(acc_q, curX, isSub);
    stepRes = addOut[31:0];
    stepOvf = addOut[34];
    stepUnf = addOut[33];
    stepExc = addOut[32];
    if (mode_q[1]) begin
      stepOvf = 1'b0;
      stepUnf = 1'b0;
      stepExc = 1'b0;
      if (isNan(acc_q) || isNan(curX)) begin
        stepRes = QNAN;
        stepExc = 1'b1;
      end
      else if (mode_q[0] ? greaterThan(acc_q, curX) : greaterThan(curX, acc_q)) stepRes = curX;
      else stepRes = acc_q;
    end
  end

  // Job sequencing: accept a start in IDLE, fold while enabled, then pulse valid once.
  always_comb begin
    state_d  = state_q;
    nums_d   = nums_q;
    mode_d   = mode_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    exc_d    = exc_q;
    case (state_q)
      IDLE: begin
        if (bus.iSTART) begin
          nums_d = bus.iFPA_NUMBERS;
          mode_d = bus.iFPA_MODE;
          acc_d  = bus.iFPA_NUMBERS[0];
          idx_d  = IDXW'(1);
          ovf_d  = 1'b0;
          unf_d  = 1'b0;
          exc_d  = 1'b0;
          if (N == 1) begin
            result_d = bus.iFPA_NUMBERS[0];
            state_d  = DONE;
          end else begin
            state_d = ACC;
          end
        end
      end
      ACC: begin
        if (bus.iEN) begin
          acc_d = stepRes;
          ovf_d = ovf_q | stepOvf;
          unf_d = unf_q | stepUnf;
          exc_d = exc_q | stepExc;
          if (idx_q == LAST_IDX) begin
            result_d = stepRes;
            state_d  = DONE;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any job in flight and zeroes every output.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state_q  <= IDLE;
      nums_q   <= '0;
      mode_q   <= 2'b00;
      acc_q    <= 32'h0;
      idx_q    <= '0;
      result_q <= 32'h0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      nums_q   <= nums_d;
      mode_q   <= mode_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      exc_q    <= exc_d;
    end
  end

  assign bus.oBUSY           = (state_q != IDLE);
  assign bus.oFPA_DATA_VALID = (state_q == DONE);
  assign bus.oFPA_RESULT     = result_q;
  assign bus.oFPA_OVERFLOW   = ovf_q;
  assign bus.oFPA_UNDERFLOW  = unf_q;
  assign bus.oFPA_EXCEPTION  = exc_q;

endmodule
